debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Multi-channel, parametrised debouncer for buttons, jumpers and status straps on the interface board.
- Each channel filters a synchronous noisy input and produces:
  - a stable level;
  - one-cycle edge pulses;
  - sticky event bits that firmware or control logic clears with a write-one-to-clear strobe.
- Rise and fall settle times are set independently (asymmetric filtering).
- A single `irq` summarises all pending events.

Parameters:
- CHANNELS, 4: number of independent channels (≥1).
- RISE_COUNT, 16: consecutive samples of `in`=1 (while `out`=0) required to raise `out` (≥1).
- FALL_COUNT, 16: consecutive samples of `in`=0 (while `out`=1) required to drop `out` (≥1).
- RESET_VALUE, {CHANNELS{1'b0}}: per-channel reset level of `out`.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  CHANNELS  raw channel inputs, synchronous to `clock` unless the optional feature is enabled.
- out  out  CHANNELS  debounced levels.
- edj  out  CHANNELS  one-cycle pulse on either edge of `out`.
- rise  out  CHANNELS  one-cycle pulse on a rising edge of `out`.
- fall  out  CHANNELS  one-cycle pulse on a falling edge of `out`.
- event_mask  out  CHANNELS  sticky bit per channel; set on any `out` edge.
- clear_mask  in  CHANNELS  write-one-to-clear strobe for `event_mask`.
- irq  out  1  registered OR of `event_mask`.

Behaviour:
- Reset (async assert, sync release):
  - `out` = RESET_VALUE;
  - all counters = 0;
  - `edj`, `rise`, `fall`, `event_mask`, `irq` = 0.
- Counter width: CW = $clog2(max(RISE_COUNT,FALL_COUNT)+1). Each channel has its own counter.
- Per channel, each clock edge, with `s` = sampled input:
  - `s == out`: counter <= 0; no pulses. Any bounce restarts qualification.
  - `s != out`: let T = RISE_COUNT if `out`=0, else FALL_COUNT.
    - If counter == T-1: `out` <= `s`; counter <= 0.
    - Otherwise: counter <= counter+1.
- Latency:
  - `out` toggles on the T-th consecutive edge at which `s != out`.
  - T=1 means one-edge latency with no filtering.
- Edge pulses are registered:
  - `rise`/`fall`/`edj` are high in exactly the cycle in which the new `out` value is first visible.
  - All pulses are 0 otherwise.
  - At most one edge per channel per T cycles.
- Counter saturation: the counter never exceeds T-1. No wrap is possible because it resets on the toggle.
- `event_mask[i]`, each edge:
  - Set when the channel's `out` toggles, i.e. coincident with its `edj`.
  - Cleared when `clear_mask[i]`=1 and no toggle occurs that edge.
  - Simultaneous set and clear: set wins, bit stays 1.
  - `clear_mask` bits with `event_mask`=0 have no effect.
- `irq`: registered `|event_mask`, so it lags `event_mask` by one cycle. It deasserts one cycle after the last bit clears.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulses and mask bits.
- Reset mid-qualification: the counter is discarded and `out` returns to RESET_VALUE. After release, qualification restarts from 0.
- Idle power: counters hold at 0 while `s == out`.

Optional Feature:
- Macro: DEBOUNCE_BANK_SYNC_EN.
- Defined:
  - Each `in` bit passes through a 2-flop synchronizer before `s`; `s` is the second flop.
  - Synchronizer flops reset to RESET_VALUE.
  - Total latency = T+2 edges from an `in` change.
  - `in` may be asynchronous.
- Undefined:
  - `s` = `in` directly; `in` must be synchronous to `clock`.
  - Latency = T edges.

Test Plan:
- Reset, CHANNELS=4, RESET_VALUE=4'b0101: hold reset_n=0, toggle `in` → `out`=0101; all pulses, `event_mask` and `irq` = 0; counters stay 0 until release.
- Clean rise, RISE_COUNT=16, ch0: `in[0]` 0→1 and held → `out[0]`, `rise[0]` and `edj[0]` high on edge 16; pulses low on edge 17; `event_mask[0]`=1 that cycle; `irq`=1 one cycle later.
- Bounce rejection, ch1: pattern 1 for 10 cycles, 0 for 1, then 1 for 16 → no toggle during the first 10; `out[1]` rises only after 16 further consecutive 1s; exactly one `rise` pulse.
- Asymmetric, RISE_COUNT=4, FALL_COUNT=32: rise after 4 samples; a 20-cycle low glitch is ignored; fall after 32 consecutive 0s.
- W1C collision: `clear_mask[2]`=1 on the same edge ch2 toggles → `event_mask[2]` stays 1. Clear next cycle → bit 0; `irq`=0 one cycle later if no other bits set.
- DEBOUNCE_BANK_SYNC_EN defined, T=16: `in[3]` step → `out[3]` toggles on edge 18; with the macro undefined, edge 16.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel asymmetric debouncer with edge pulses, sticky W1C events and irq.
// Optional macro DEBOUNCE_BANK_SYNC_EN adds a 2-flop input synchronizer ahead of the filter.
module debounce_bank #(
    parameter int                    CHANNELS    = 4,
    parameter int                    RISE_COUNT  = 16,
    parameter int                    FALL_COUNT  = 16,
    parameter logic [CHANNELS-1:0]   RESET_VALUE = {CHANNELS{1'b0}}
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] edj,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] event_mask,
    input  logic [CHANNELS-1:0] clear_mask,
    output logic                irq
);

    localparam int MAX_COUNT = (RISE_COUNT > FALL_COUNT) ? RISE_COUNT : FALL_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] RISE_LAST = CW'(RISE_COUNT - 1);
    localparam logic [CW-1:0] FALL_LAST = CW'(FALL_COUNT - 1);

    logic [CHANNELS-1:0] samp_s;
    logic [CHANNELS-1:0] tog_s;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] edj_q, edj_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] event_q, event_d;
    logic                irq_q, irq_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    // Two-stage synchronizer; reset to the idle level so no spurious qualification starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign samp_s = sync2_q;
`else
    assign samp_s = in;
`endif

    // Per-channel qualification counters; threshold depends on the current level direction.
    always_comb begin
        out_d = out_q;
        tog_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = {CW{1'b0}};
            if (samp_s[i] != out_q[i]) begin
                if (cnt_q[i] == (out_q[i] ? FALL_LAST : RISE_LAST)) begin
                    out_d[i] = samp_s[i];
                    tog_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = {CW{1'b0}};
            end
        end
    end

    // Pulses, sticky events (set wins over clear) and the lagging irq summary.
    always_comb begin
        edj_d   = tog_s;
        rise_d  = tog_s & samp_s;
        fall_d  = tog_s & ~samp_s;
        event_d = tog_s | (event_q & ~clear_mask);
        irq_d   = |event_q;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= RESET_VALUE;
            edj_q   <= {CHANNELS{1'b0}};
            rise_q  <= {CHANNELS{1'b0}};
            fall_q  <= {CHANNELS{1'b0}};
            event_q <= {CHANNELS{1'b0}};
            irq_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            out_q   <= out_d;
            edj_q   <= edj_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
            irq_q   <= irq_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out        = out_q;
    assign edj        = edj_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign event_mask = event_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: per-cycle scoreboard against a behavioural model plus directed checks.
module tb_debounce_bank;

    localparam int              NCH  = 4;
    localparam int              RISE = 5;
    localparam int              FALL = 9;
    localparam logic [NCH-1:0]  RV   = 4'b0101;
`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int              LAT  = 2;
`else
    localparam int              LAT  = 0;
`endif

    logic           clock;
    logic           reset_n;
    logic [NCH-1:0] din;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] dout, edj, rise, fall, evm;
    logic           irq;

    int checks = 0;
    int errors = 0;

    logic [5*NCH:0] exp_q [$];

    logic [NCH-1:0] m_out, m_ev, m_s1, m_s2;
    int             m_cnt [NCH];

    debounce_bank #(
        .CHANNELS   (NCH),
        .RISE_COUNT (RISE),
        .FALL_COUNT (FALL),
        .RESET_VALUE(RV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (din),
        .out       (dout),
        .edj       (edj),
        .rise      (rise),
        .fall      (fall),
        .event_mask(evm),
        .clear_mask(clr),
        .irq       (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [5*NCH:0] observed();
        return {dout, edj, rise, fall, evm, irq};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = RV;
        m_ev  = '0;
        m_s1  = RV;
        m_s2  = RV;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    // Advance the reference model by one clock edge and queue the expected outputs.
    task automatic model_edge(input logic [NCH-1:0] in_v, input logic [NCH-1:0] clr_v);
        logic [NCH-1:0] s, tog, nout;
        int thr;
        tog = '0;
        if (LAT == 2) begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = in_v;
        end else begin
            s = in_v;
        end
        for (int i = 0; i < NCH; i++) begin
            thr = m_out[i] ? FALL : RISE;
            if (s[i] !== m_out[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] >= thr) begin
                    tog[i]   = 1'b1;
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        nout = m_out ^ tog;
        exp_q.push_back({nout, tog, tog & nout, tog & ~nout, tog | (m_ev & ~clr_v), |m_ev});
        m_ev  = tog | (m_ev & ~clr_v);
        m_out = nout;
    endtask

    // One cycle: drive at negedge, let the posedge happen, compare at the following negedge.
    task automatic step(input logic [NCH-1:0] in_v, input logic [NCH-1:0] clr_v, input string tag);
        logic [5*NCH:0] e;
        din = in_v;
        clr = clr_v;
        model_edge(in_v, clr_v);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        chk(tag, 32'(observed()), 32'(e));
    endtask

    initial begin
        int rise_seen;
        int len;
        logic [NCH-1:0] v, c;
        reset_n = 1'b0;
        din     = '0;
        clr     = '0;
        model_reset();

        // Reset held: inputs wiggle, outputs stay at reset state.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            din = k[0] ? 4'b1111 : 4'b0000;
            clr = 4'b1111;
            #1 chk("reset_hold", 32'(observed()), 32'({RV, 16'h0000, 1'b0}));
        end
        @(negedge clock);
        din = RV;
        clr = '0;
        reset_n = 1'b1;

        // Clean rise on ch1 with directed latency checks.
        for (int k = 1; k <= RISE + LAT + 2; k++) begin
            step(4'b0111, 4'b0000, "clean_rise");
            if (k == RISE + LAT - 1) chk("rise_not_early", 32'(dout[1]), 32'd0);
            if (k == RISE + LAT)     chk("rise_on_time", 32'({dout[1], rise[1], edj[1], evm[1]}), 32'hF);
            if (k == RISE + LAT + 1) chk("rise_pulse_end", 32'({rise[1], edj[1], irq}), 32'h1);
        end

        // Bounce on ch3: short high burst, one low sample, then a full qualification.
        rise_seen = 0;
        for (int k = 0; k < 3; k++) step(4'b1111, 4'b0000, "bounce_pre");
        step(4'b0111, 4'b0000, "bounce_gap");
        chk("bounce_no_toggle", 32'(dout[3]), 32'd0);
        for (int k = 0; k < RISE + LAT + 3; k++) begin
            step(4'b1111, 4'b0000, "bounce_post");
            rise_seen += int'(rise[3]);
        end
        chk("bounce_one_rise", 32'(rise_seen), 32'd1);

        // Asymmetric fall on ch0: a low glitch shorter than FALL is ignored.
        for (int k = 0; k < FALL - 2; k++) step(4'b1110, 4'b0000, "glitch_low");
        chk("glitch_ignored", 32'(dout[0]), 32'd1);
        for (int k = 0; k < 3; k++) step(4'b1111, 4'b0000, "glitch_back");
        for (int k = 1; k <= FALL + LAT + 1; k++) begin
            step(4'b1110, 4'b0000, "asym_fall");
            if (k == FALL + LAT) chk("fall_on_time", 32'({dout[0], fall[0]}), 32'h1);
        end

        // Clear everything pending, then W1C collision on ch2.
        step(4'b1110, 4'b1111, "clear_all");
        step(4'b1110, 4'b0000, "irq_drop");
        chk("irq_cleared", 32'(irq), 32'd0);
        for (int k = 1; k <= FALL + LAT; k++) begin
            step(4'b1010, 4'b0100, "w1c_collide");
            if (k == FALL + LAT) chk("set_wins", 32'({dout[2], evm[2]}), 32'h1);
        end
        step(4'b1010, 4'b0100, "w1c_clear");
        chk("w1c_bit_clear", 32'(evm[2]), 32'd0);
        step(4'b1010, 4'b0000, "w1c_irq");
        chk("w1c_irq_low", 32'(irq), 32'd0);

        // All channels flip together.
        for (int k = 0; k < FALL + LAT + 2; k++) step(4'b0101, 4'b0000, "multi_flip");

        // Mid-qualification reset.
        for (int k = 0; k < 3; k++) step(m_out ^ 4'b1111, 4'b0000, "pre_reset");
        #2 reset_n = 1'b0;
        #1 chk("mid_reset", 32'(observed()), 32'({RV, 16'h0000, 1'b0}));
        model_reset();
        @(negedge clock);
        din = RV;
        reset_n = 1'b1;
        for (int k = 0; k < RISE + LAT - 1; k++) step(4'b0111, 4'b0000, "requalify");
        chk("requalify_from_zero", 32'(dout[1]), 32'd0);
        for (int k = 0; k < 3; k++) step(4'b0111, 4'b0000, "requalify_done");

        // Random held levels with random clears.
        for (int seg = 0; seg < 40; seg++) begin
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                step(v, c, "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
